instr_loader: RTL and testbench

Boot-time program loader that fills the CPU's instruction memory from an external byte stream, acting as the writer side of the instruction-memory interface that the CPU only reads. It accepts a length-prefixed big-endian byte stream over a valid/ready handshake, packs bytes into 32-bit words, and issues one write per word at consecutive word-aligned byte addresses starting at 0. It holds the CPU in reset until the whole program is loaded.

---
 rtl/instr_loader.sv | 117 +++++++++++
 tb/tb_instr_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Boot-time program loader: receives a length-prefixed big-endian byte stream,
// packs it into 32-bit words and writes them to instruction memory from address 0.
module instr_loader #(
  parameter int n     = 32,
  parameter int WORDS = 64
) (
  input  logic         clock,
  input  logic         rst,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic         byte_ready,
  output logic         imem_we,
  output logic [n-1:0] imem_addr,
  output logic [n-1:0] imem_wdata,
  output logic         cpu_rst,
  output logic         done,
  output logic         err
);

  localparam int IW = $clog2(WORDS + 1);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t          state;
  logic [15:0]     count;
  logic [1:0]      byte_cnt;
  logic [IW-1:0]   word_idx;
  logic [23:0]     shift_reg;
  logic            xfer;
  logic [15:0]     full_count;

  // Ready depends on rst directly so no byte is accepted during a reset cycle.
  always_comb begin
    byte_ready = !rst && (state == HDR_HI || state == HDR_LO || state == DATA);
    xfer       = byte_valid && byte_ready;
    full_count = {count[15:8], byte_in};
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= HDR_HI;
      count      <= '0;
      byte_cnt   <= '0;
      word_idx   <= '0;
      shift_reg  <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        HDR_HI: begin
          if (xfer) begin
            count[15:8] <= byte_in;
            state       <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (xfer) begin
            count[7:0] <= byte_in;
            byte_cnt   <= '0;
            word_idx   <= '0;
            if (full_count == 16'd0) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else if (full_count > 16'(WORDS)) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            shift_reg <= {shift_reg[15:0], byte_in};
            byte_cnt  <= byte_cnt + 2'd1;
            // The 4th byte goes straight into the write word, so the write
            // registers are loaded on the same edge that accepts it.
            if (byte_cnt == 2'd3) begin
              state      <= WRITE;
              imem_we    <= 1'b1;
              imem_addr  <= n'({word_idx, 2'b00});
              imem_wdata <= n'({shift_reg, byte_in});
            end
          end
        end
        WRITE: begin
          word_idx <= word_idx + 1'b1;
          byte_cnt <= '0;
          if (16'(word_idx) + 16'd1 == count) begin
            state   <= DONE;
            done    <= 1'b1;
            cpu_rst <= 1'b0;
          end else begin
            state <= DATA;
          end
        end
        DONE, ERR: begin
        end
        default: state <= HDR_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed and randomized program loads
// checked against a word-list model derived from the stream format.
module tb_instr_loader;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  instr_loader #(.n(32), .WORDS(64)) dut (
    .clock(clock),
    .rst(rst),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst),
    .done(done),
    .err(err)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int writes_seen = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] last_addr;
  logic [31:0] last_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Every write pulse must match the next word the model predicts.
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      writes_seen++;
      check("we_ready_low", {31'd0, byte_ready}, 32'd0);
      if (exp_addr_q.size() == 0) begin
        check("unexpected_we", {31'd0, imem_we}, 32'd0);
      end else begin
        check("wr_addr", imem_addr, exp_addr_q.pop_front());
        check("wr_data", imem_wdata, exp_data_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b1;
    byte_valid = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    @(negedge clock);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, byte_ready}, 32'd1);
  endtask

  // Offers one byte after 'gap' idle cycles; returns at the negedge after it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clock);
    byte_valid = 1'b1;
    byte_in = b;
    for (int t = 0; ; t++) begin
      if (byte_ready === 1'b1) begin
        @(posedge clock);
        break;
      end
      if (t >= 40) begin
        check("ready_timeout", {31'd0, byte_ready}, 32'd1);
        byte_valid = 1'b0;
        return;
      end
      @(negedge clock);
    end
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  // gap < 0 selects a random 0..3 idle cycles before each byte.
  task automatic run_load(input int c, input int gap, input bit use_first, input logic [31:0] first);
    logic [31:0] words[$];
    logic [7:0]  stream[$];
    logic [31:0] w;
    int          start_writes;
    words.delete();
    stream.delete();
    stream.push_back(8'((c >> 8) & 255));
    stream.push_back(8'(c & 255));
    if (c >= 1 && c <= 64) begin
      for (int i = 0; i < c; i++) begin
        w = (i == 0 && use_first) ? first : $urandom;
        words.push_back(w);
        for (int k = 3; k >= 0; k--) stream.push_back(8'((w >> (8 * k)) & 32'hFF));
        exp_addr_q.push_back(32'(4 * i));
        exp_data_q.push_back(w);
      end
    end
    start_writes = writes_seen;
    foreach (stream[i]) send_byte(stream[i], (gap < 0) ? int'($urandom_range(0, 3)) : gap);

    if (c == 0) begin
      check("c0_done", {31'd0, done}, 32'd1);
      check("c0_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      check("c0_err", {31'd0, err}, 32'd0);
      repeat (3) @(negedge clock);
      check("c0_writes", 32'(writes_seen - start_writes), 32'd0);
    end else if (c > 64) begin
      check("err_flag", {31'd0, err}, 32'd1);
      check("err_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      check("err_done", {31'd0, done}, 32'd0);
      byte_valid = 1'b1;
      byte_in = 8'($urandom);
      repeat (6) begin
        @(negedge clock);
        check("err_ready", {31'd0, byte_ready}, 32'd0);
        check("err_hold", {31'd0, err}, 32'd1);
      end
      byte_valid = 1'b0;
      check("err_writes", 32'(writes_seen - start_writes), 32'd0);
    end else begin
      // Final write is on the bus now; the CPU must still be held in reset.
      check("last_wr_done", {31'd0, done}, 32'd0);
      check("last_wr_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      @(negedge clock);
      check("fin_done", {31'd0, done}, 32'd1);
      check("fin_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      check("fin_we", {31'd0, imem_we}, 32'd0);
      check("fin_writes", 32'(writes_seen - start_writes), 32'(c));
      check("fin_pending", 32'(exp_addr_q.size()), 32'd0);
      last_addr = 32'(4 * (c - 1));
      last_data = words[c - 1];
    end
  endtask

  initial begin
    do_reset();
    run_load(1, 0, 1'b1, 32'h20080005);

    // Flood a finished loader; nothing may be consumed or change.
    byte_valid = 1'b1;
    byte_in = 8'hFF;
    repeat (10) begin
      @(negedge clock);
      check("flood_ready", {31'd0, byte_ready}, 32'd0);
      check("flood_done", {31'd0, done}, 32'd1);
      check("flood_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      check("flood_addr", imem_addr, last_addr);
      check("flood_wdata", imem_wdata, last_data);
    end
    byte_valid = 1'b0;

    do_reset();
    run_load(3, 2, 1'b0, 32'd0);
    do_reset();
    run_load(0, 0, 1'b0, 32'd0);
    do_reset();
    run_load(65, 0, 1'b0, 32'd0);

    // Reset with half a word assembled: no write may escape.
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    do_reset();
    check("midrst_writes", 32'(writes_seen), 32'd1 + 32'd3);
    run_load(1, 1, 1'b1, 32'hCAFE0001);

    do_reset();
    run_load(64, 0, 1'b0, 32'd0);

    for (int r = 0; r < 6; r++) begin
      do_reset();
      run_load(int'($urandom_range(1, 8)), -1, 1'b0, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    check("global_timeout", 32'd1, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "FAIL global_timeout: simulation did not finish");
  end

endmodule
